instr_buffer: RTL
=================

# instr_buffer

Circular instruction buffer between fetch and dispatch. Each cycle it accepts up to `IB_PUSH_WIDTH` fetched instructions, compacting away invalid lanes, and stores them in program order. It presents up to `IB_POP_WIDTH` oldest entries to dispatch, and it reports a registered free-slot count that fetch uses for its stall decision. A single flush input empties it on branch mispredict recovery.

## Interface
Parameters:
- `DEPTH`, default `` `IB_SZ `` (16): number of entries. Must be a power of 2 and ≥ `PUSH_WIDTH`.
- `PUSH_WIDTH`, default `` `IB_PUSH_WIDTH `` (4): number of fetch lanes.
- `POP_WIDTH`, default `` `IB_POP_WIDTH `` (3): dispatch width.

Ports:
- `clock`, in, 1: the single clock. All state updates on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `fetch_packet`, in, `[PUSH_WIDTH-1:0]` `FETCH_PACKET`: lanes from fetch. Only lanes with `.valid` set are stored.
- `num_pushes`, in, `$clog2(PUSH_WIDTH+1)`: count of valid lanes. Equals popcount of the lane valid bits.
- `ib_free_slots`, out, `` `IB_IDX_BITS+1 ``: `DEPTH - count`, registered.
- `flush`, in, 1: empty the buffer (mispredict recovery).
- `dispatch_packet`, out, `[POP_WIDTH-1:0]` `FETCH_PACKET`: slot i = (i)th oldest entry; `.valid` = i < `num_available`.
- `num_available`, out, `$clog2(POP_WIDTH+1)`: `min(count, POP_WIDTH)`.
- `num_pops`, in, `$clog2(POP_WIDTH+1)`: entries consumed by dispatch this cycle. Must be ≤ `num_available`.

## Operation
- State: `head`, `tail` (`IB_IDX_BITS` each, wrap mod `DEPTH`), `count` (`IB_IDX_BITS+1`), entry array.
- **Compaction:** valid lanes are packed in ascending lane order.
  - Example: lanes {0 invalid, 1, 2, 3} store as consecutive entries L1, L2, L3.
  - The kth valid lane is written to `(tail + k) mod DEPTH`.
- **Push:** when not flushing, `tail += num_pushes` and the packed entries are written.
- **Pop:** when not flushing, `head += num_pops`.
- **Count:** `count += num_pushes - num_pops`. Simultaneous push and pop is legal in any state, including full and empty.
- **Overflow guard:** if `num_pushes > ib_free_slots`, the whole bundle is dropped (no partial write) and an assertion fires. Fetch never does this legally.
- **Underflow guard:** if `num_pops > num_available`, an assertion fires and `num_pops` is clamped to `num_available`.
- **Flush:** wins over push and pop in the same cycle. Next state is `head = tail = count = 0`, and all stored valid bits are cleared.
- **Dispatch outputs:** combinational reads of the entry array at `head+i`. Fields of slots i ≥ `num_available` are don't-care, but their `.valid` is 0.
- **Branch metadata:** `is_branch`, `bp_pred_*` and `bp_ghr_snapshot` are stored and forwarded unchanged.

## Timing
- **Reset (async assert):** `head = tail = count = 0`; `ib_free_slots = DEPTH`; `num_available = 0`; all `dispatch_packet[*].valid = 0`. Deassertion is synchronous to `clock`.
- **Push-to-dispatch latency:** 1 cycle. A bundle pushed in cycle N is visible on `dispatch_packet` in N+1. There is no same-cycle bypass.
- **Free-slot count:** `ib_free_slots` reflects state at the start of the cycle.
  - Same-cycle pops are not credited. This is conservative and guarantees no overflow when fetch pushes while full-minus-k.
  - Pops become visible in `ib_free_slots` the next cycle.
- **Flush:** asserted in cycle N gives `ib_free_slots = DEPTH` and `num_available = 0` in N+1. Pushes and pops in N are ignored.
- **Full/empty:** `count == DEPTH` gives `ib_free_slots = 0`. `count == 0` gives `num_available = 0`.

## Configuration
- `IB_STATS_EN` defined adds three 32-bit outputs, all reset to 0 and held at 0 while `reset_n` is low:
  - `stat_full_cycles`: increments every cycle with `count == DEPTH`.
  - `stat_empty_cycles`: increments every cycle with `count == 0`.
  - `stat_flushes`: increments every cycle `flush` is high.
- `IB_STATS_EN` undefined: these ports and counters do not exist; functional behaviour is identical.

## Structure
- Shared in `sys_defs.svh`:
  - `FETCH_PACKET` (existing)
  - `` `IB_SZ ``, `` `IB_IDX_BITS `` (= `$clog2(`IB_SZ)`), `` `IB_PUSH_WIDTH ``, `` `IB_POP_WIDTH ``
- One combinational sub-module, `ib_compact`. It maps `PUSH_WIDTH` lanes plus their valid bits to packed entries with per-output valid bits, using prefix popcount.
- Pointer, count and array logic live in `instr_buffer`.

## Test plan
- **Reset, then a 4-lane push:** reset, then push 4 valid lanes with PCs 0, 4, 8, 12.
  - Next cycle: `ib_free_slots` = 12, `num_available` = 3, dispatch PCs 0, 4, 8.
- **Misaligned push:** push lanes {invalid, 4, 8, 12} with `num_pushes` = 3.
  - Next cycle: dispatch slots 0–2 = PCs 4, 8, 12 and `num_available` = 3.
- **Fill, full push and simultaneous pop:**
  - Four 4-wide pushes with no pops give `ib_free_slots` = 0.
  - Then pop 3 while fetch presents 4 (stalled, `num_pushes` = 0). Next cycle `ib_free_slots` = 3 and ordering is preserved.
- **Wrap-around:** cycle 24 entries through the buffer with alternating push 4 / pop 3 patterns.
  - The dispatched PC sequence must be strictly +4 monotonic across the pointer wrap.
- **Flush priority:** in one cycle, `flush` = 1, `num_pushes` = 4 and `num_pops` = 2.
  - Next cycle: `ib_free_slots` = 16 and `num_available` = 0.
  - A subsequent push of PC 0x100 dispatches first.
- **Async reset mid-operation:** with the buffer at `count` = 7, drive `reset_n` low between clock edges.
  - Outputs go to reset values immediately, before the next edge.
  - With `IB_STATS_EN` defined, all counters read 0.

Source files
------------

// File: rtl/instr_buffer_pkg.sv
// Shared types and sizing for the fetch-to-dispatch instruction buffer.
// Optional statistics counters in instr_buffer are enabled by IB_STATS_EN.
package instr_buffer_pkg;

    localparam int IB_SZ         = 16;
    localparam int IB_IDX_BITS   = $clog2(IB_SZ);
    localparam int IB_PUSH_WIDTH = 4;
    localparam int IB_POP_WIDTH  = 3;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        is_branch;
        logic        bp_pred_taken;
        logic [31:0] bp_pred_target;
        logic [7:0]  bp_ghr_snapshot;
    } FETCH_PACKET;

endpackage

// File: rtl/instr_buffer_compact.sv
// Packs valid fetch lanes into consecutive slots in ascending lane order.
// Purely combinational; output slot k holds the kth valid lane.
module ib_compact
    import instr_buffer_pkg::*;
#(
    parameter int WIDTH = IB_PUSH_WIDTH
) (
    input  FETCH_PACKET [WIDTH-1:0] lanes_in,
    output FETCH_PACKET [WIDTH-1:0] packed_out,
    output logic [WIDTH-1:0]        packed_valid
);

    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] pos;

    // Running prefix popcount selects each valid lane's packed slot
    always_comb begin
        packed_out   = '0;
        packed_valid = '0;
        pos          = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (lanes_in[i].valid) begin
                packed_out[IW'(pos)]   = lanes_in[i];
                packed_valid[IW'(pos)] = 1'b1;
                pos                    = pos + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_buffer.sv
// Circular instruction buffer between fetch and dispatch.
// Define IB_STATS_EN to add full/empty/flush cycle counters.
module instr_buffer
    import instr_buffer_pkg::*;
#(
    parameter int DEPTH      = IB_SZ,
    parameter int PUSH_WIDTH = IB_PUSH_WIDTH,
    parameter int POP_WIDTH  = IB_POP_WIDTH
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  FETCH_PACKET [PUSH_WIDTH-1:0]    fetch_packet,
    input  logic [$clog2(PUSH_WIDTH+1)-1:0] num_pushes,
    output logic [$clog2(DEPTH):0]          ib_free_slots,
    input  logic                            flush,
    output FETCH_PACKET [POP_WIDTH-1:0]     dispatch_packet,
    output logic [$clog2(POP_WIDTH+1)-1:0]  num_available,
`ifdef IB_STATS_EN
    output logic [31:0]                     stat_full_cycles,
    output logic [31:0]                     stat_empty_cycles,
    output logic [31:0]                     stat_flushes,
`endif
    input  logic [$clog2(POP_WIDTH+1)-1:0]  num_pops
);

    localparam int IW  = $clog2(DEPTH);
    localparam int CW  = IW + 1;
    localparam int POW = $clog2(POP_WIDTH + 1);

    logic [IW-1:0] head_q, head_d;
    logic [IW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] free_q, free_d;
    FETCH_PACKET   mem_q [DEPTH];
    FETCH_PACKET   mem_d [DEPTH];

    FETCH_PACKET [PUSH_WIDTH-1:0] packed_pkt;
    logic [PUSH_WIDTH-1:0]        packed_vld;
    logic                         push_ok;
    logic [POW-1:0]               pops_eff;

    ib_compact #(
        .WIDTH(PUSH_WIDTH)
    ) u_compact (
        .lanes_in    (fetch_packet),
        .packed_out  (packed_pkt),
        .packed_valid(packed_vld)
    );

    // Occupancy view for dispatch and guards against illegal push/pop
    always_comb begin
        if (count_q >= CW'(POP_WIDTH)) begin
            num_available = POW'(POP_WIDTH);
        end else begin
            num_available = POW'(count_q);
        end
        pops_eff = (num_pops > num_available) ? num_available : num_pops;
        push_ok  = CW'(num_pushes) <= free_q;
    end

    // Pointer, count and entry array next state; flush overrides all
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_d[k].valid = 1'b0;
            end
        end else begin
            head_d  = head_q + IW'(pops_eff);
            count_d = count_q - CW'(pops_eff);
            if (push_ok) begin
                tail_d  = tail_q + IW'(num_pushes);
                count_d = count_d + CW'(num_pushes);
                for (int k = 0; k < PUSH_WIDTH; k++) begin
                    if (packed_vld[k] && (CW'(k) < CW'(num_pushes))) begin
                        mem_d[tail_q + IW'(k)] = packed_pkt[k];
                    end
                end
            end
        end
        free_d = CW'(DEPTH) - count_d;
    end

    // State registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            free_q  <= CW'(DEPTH);
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            free_q  <= free_d;
            mem_q   <= mem_d;
        end
    end

    assign ib_free_slots = free_q;

    // Oldest entries read straight from the array, masked by occupancy
    always_comb begin
        for (int i = 0; i < POP_WIDTH; i++) begin
            dispatch_packet[i]       = mem_q[head_q + IW'(i)];
            dispatch_packet[i].valid = POW'(i) < num_available;
        end
    end

    ovf_a: assert property (@(posedge clock) disable iff (!reset_n)
        flush || push_ok);

    unf_a: assert property (@(posedge clock) disable iff (!reset_n)
        flush || (num_pops <= num_available));

`ifdef IB_STATS_EN
    logic [31:0] full_q, full_d;
    logic [31:0] empty_q, empty_d;
    logic [31:0] flushes_q, flushes_d;

    // Occupancy and recovery event counters
    always_comb begin
        full_d    = full_q + 32'(count_q == CW'(DEPTH));
        empty_d   = empty_q + 32'(count_q == '0);
        flushes_d = flushes_q + 32'(flush);
    end

    // Counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full_q    <= '0;
            empty_q   <= '0;
            flushes_q <= '0;
        end else begin
            full_q    <= full_d;
            empty_q   <= empty_d;
            flushes_q <= flushes_d;
        end
    end

    assign stat_full_cycles  = full_q;
    assign stat_empty_cycles = empty_q;
    assign stat_flushes      = flushes_q;
`endif

endmodule
